// File: rtl/outport_buffered.sv
// Multi-channel buffered output port: bus writes are steered into per-channel FIFOs
// that drain over valid/ready. Optional OUTPORT_LAST_VALUE_EN adds a per-channel last_data view.
module outport_buffered #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            bus_in,
    input  logic                         OutPortin,
    input  logic [SEL_W-1:0]             ch_sel,
    output logic                         port_stall,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready,
    output logic [CHANNELS-1:0]          ch_full,
    output logic [CHANNELS-1:0]          overflow,
    input  logic [CHANNELS-1:0]          ovf_clr
`ifdef OUTPORT_LAST_VALUE_EN
    ,
    output logic [CHANNELS*DATA_W-1:0]   last_data
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0]   mem_q      [CHANNELS][DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q   [CHANNELS];
    logic [PTR_W-1:0]    wr_ptr_d   [CHANNELS];
    logic [PTR_W-1:0]    rd_ptr_q   [CHANNELS];
    logic [PTR_W-1:0]    rd_ptr_d   [CHANNELS];
    logic [CNT_W-1:0]    count_q    [CHANNELS];
    logic [CNT_W-1:0]    count_d    [CHANNELS];
    logic [CHANNELS-1:0] overflow_q;
    logic [CHANNELS-1:0] overflow_d;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] stall_vec;
    logic [31:0]         sel_idx;

    // A full channel that drains this cycle still accepts the write.
    always_comb begin
        sel_idx   = 32'(ch_sel);
        hit       = '0;
        push      = '0;
        pop       = '0;
        stall_vec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hit[c]       = OutPortin && (sel_idx == 32'(c));
            pop[c]       = (count_q[c] != '0) && out_ready[c];
            push[c]      = hit[c] && ((count_q[c] != FULL_CNT) || pop[c]);
            stall_vec[c] = hit[c] && (count_q[c] == FULL_CNT) && !pop[c];
        end
    end

    always_comb begin
        overflow_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            count_d[c]  = count_q[c];
            if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
            if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
            case ({push[c], pop[c]})
                2'b10:   count_d[c] = count_q[c] + CNT_W'(1);
                2'b01:   count_d[c] = count_q[c] - CNT_W'(1);
                default: count_d[c] = count_q[c];
            endcase
            // A rejected write in the same cycle as a clear leaves the flag set.
            overflow_d[c] = stall_vec[c] | (overflow_q[c] & ~ovf_clr[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            overflow_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; only the pointers and counts decide what is visible.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus_in;
        end
    end

    always_comb begin
        out_valid = '0;
        ch_full   = '0;
        out_data  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            out_valid[c] = (count_q[c] != '0);
            ch_full[c]   = (count_q[c] == FULL_CNT);
            if (count_q[c] != '0) out_data[c*DATA_W +: DATA_W] = mem_q[c][rd_ptr_q[c]];
        end
    end

    assign port_stall = |stall_vec;
    assign overflow   = overflow_q;

`ifdef OUTPORT_LAST_VALUE_EN
    logic [CHANNELS*DATA_W-1:0] last_q;
    logic [CHANNELS*DATA_W-1:0] last_d;

    always_comb begin
        last_d = last_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) last_d[c*DATA_W +: DATA_W] = bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) last_q <= '0;
        else       last_q <= last_d;
    end

    assign last_data = last_q;
`else
    // Legacy last-value view not built.
`endif

endmodule

// File: tb/tb_outport_buffered.sv
// Self-checking bench for outport_buffered: directed steps then random traffic,
// compared against per-channel queue model.
module tb_outport_buffered;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4;
    localparam int CHANNELS = 2;
    localparam int SEL_W    = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [DATA_W-1:0]          bus_in;
    logic                       OutPortin;
    logic [SEL_W-1:0]           ch_sel;
    logic                       port_stall;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic [CHANNELS-1:0]        out_valid;
    logic [CHANNELS-1:0]        out_ready;
    logic [CHANNELS-1:0]        ch_full;
    logic [CHANNELS-1:0]        overflow;
    logic [CHANNELS-1:0]        ovf_clr;
`ifdef OUTPORT_LAST_VALUE_EN
    logic [CHANNELS*DATA_W-1:0] last_data;
`endif

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]                q0[$];
    logic [31:0]                q1[$];
    logic [CHANNELS-1:0]        m_ovf;
    logic [CHANNELS*DATA_W-1:0] m_last;

    always #5 clk = ~clk;

    outport_buffered #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_in(bus_in),
        .OutPortin(OutPortin),
        .ch_sel(ch_sel),
        .port_stall(port_stall),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ch_full(ch_full),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
`ifdef OUTPORT_LAST_VALUE_EN
        ,
        .last_data(last_data)
`endif
    );

    function automatic int msize(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [31:0] mfront(input int c);
        if (msize(c) == 0) return 32'h0;
        return (c == 0) ? q0[0] : q1[0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [CHANNELS-1:0]        e_valid;
        logic [CHANNELS-1:0]        e_full;
        logic [CHANNELS*DATA_W-1:0] e_data;
        e_valid = '0;
        e_full  = '0;
        e_data  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            e_valid[c] = msize(c) > 0;
            e_full[c]  = msize(c) == DEPTH;
            e_data[c*DATA_W +: DATA_W] = mfront(c);
        end
        check("out_valid", 128'(out_valid), 128'(e_valid));
        check("ch_full",   128'(ch_full),   128'(e_full));
        check("overflow",  128'(overflow),  128'(m_ovf));
        check("out_data",  128'(out_data),  128'(e_data));
`ifdef OUTPORT_LAST_VALUE_EN
        check("last_data", 128'(last_data), 128'(m_last));
`endif
    endtask

    // One clock: drive inputs, check combinational stall, advance model on the edge, check state.
    task automatic cycle(input logic rst, input logic wr, input logic [SEL_W-1:0] sel,
                         input logic [31:0] data, input logic [CHANNELS-1:0] rdy,
                         input logic [CHANNELS-1:0] clr);
        logic [CHANNELS-1:0] pop_v;
        logic [CHANNELS-1:0] hit_v;
        logic                e_stall;
        int                  sz;
        reset = rst; OutPortin = wr; ch_sel = sel; bus_in = data; out_ready = rdy; ovf_clr = clr;
        e_stall = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            pop_v[c] = (msize(c) > 0) && rdy[c];
            hit_v[c] = wr && (int'(sel) == c);
            if (hit_v[c] && msize(c) == DEPTH && !pop_v[c]) e_stall = 1'b1;
        end
        #1;
        check("port_stall", 128'(port_stall), 128'(e_stall));
        @(posedge clk);
        if (rst) begin
            q0.delete(); q1.delete();
            m_ovf  = '0;
            m_last = '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                sz = msize(c);
                if (pop_v[c]) begin
                    if (c == 0) void'(q0.pop_front());
                    else        void'(q1.pop_front());
                end
                if (hit_v[c] && (sz < DEPTH || pop_v[c])) begin
                    if (c == 0) q0.push_back(data);
                    else        q1.push_back(data);
                    m_last[c*DATA_W +: DATA_W] = data;
                end
                if (hit_v[c] && sz == DEPTH && !pop_v[c]) m_ovf[c] = 1'b1;
                else if (clr[c])                          m_ovf[c] = 1'b0;
            end
        end
        #1;
        check_state();
    endtask

    initial begin
        logic [31:0] drain_exp [4];
        q0.delete(); q1.delete();
        m_ovf  = '0;
        m_last = '0;
        reset = 1'b1; OutPortin = 1'b0; ch_sel = '0; bus_in = '0; out_ready = '0; ovf_clr = '0;

        cycle(1, 0, 0, 0, 2'b00, 2'b00);
        cycle(1, 0, 0, 0, 2'b00, 2'b00);
        check("reset_valid", 128'(out_valid), 128'(2'b00));

        // Single write to ch0, visible next cycle
        cycle(0, 1, 0, 32'h0000_00AA, 2'b00, 2'b00);
        check("aa_valid", 128'(out_valid), 128'(2'b01));
        check("aa_data0", 128'(out_data[31:0]), 128'(32'hAA));
        check("aa_data1", 128'(out_data[63:32]), 128'(32'h0));

        // Fill ch1, then overflow, then clear
        for (int i = 1; i <= 4; i++) cycle(0, 1, 1, 32'(i), 2'b00, 2'b00);
        check("ch1_full", 128'(ch_full[1]), 128'(1'b1));
        cycle(0, 1, 1, 32'd5, 2'b00, 2'b00);
        check("ch1_ovf_set", 128'(overflow[1]), 128'(1'b1));
        cycle(0, 0, 0, 0, 2'b00, 2'b10);
        check("ch1_ovf_clr", 128'(overflow[1]), 128'(1'b0));

        // Full ch1 drained while written: accepted
        cycle(0, 1, 1, 32'd5, 2'b10, 2'b00);
        check("ch1_still_full", 128'(ch_full[1]), 128'(1'b1));
        check("ch1_no_ovf", 128'(overflow[1]), 128'(1'b0));
        drain_exp[0] = 32'd2; drain_exp[1] = 32'd3; drain_exp[2] = 32'd4; drain_exp[3] = 32'd5;
        for (int i = 0; i < 4; i++) begin
            check("ch1_drain", 128'(out_data[63:32]), 128'(drain_exp[i]));
            cycle(0, 0, 0, 0, 2'b10, 2'b00);
        end
        check("ch1_empty", 128'(out_valid[1]), 128'(1'b0));

        // Continuous drain of ch0 across pointer wrap
        for (int i = 1; i <= 7; i++) cycle(0, 1, 0, 32'(i * 16), 2'b01, 2'b00);
        cycle(0, 0, 0, 0, 2'b01, 2'b00);
        check("ch0_wrap_empty", 128'(out_valid[0]), 128'(1'b0));

        // Mid-stream reset discards buffered data
        for (int i = 1; i <= 3; i++) cycle(0, 1, 0, 32'(i), 2'b00, 2'b00);
        cycle(1, 0, 0, 0, 2'b11, 2'b00);
        check("rst_valid", 128'(out_valid), 128'(2'b00));
        check("rst_data", 128'(out_data), 128'(64'h0));
        cycle(0, 1, 0, 32'h55, 2'b00, 2'b00);
        check("post_rst_55", 128'(out_data[31:0]), 128'(32'h55));

        // Out-of-range select is ignored
        cycle(0, 1, 3, 32'hDEAD_BEEF, 2'b00, 2'b00);
        cycle(0, 1, 2, 32'hCAFE_F00D, 2'b00, 2'b00);
        check("badsel_valid", 128'(out_valid), 128'(2'b01));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  SEL_W'($urandom_range(0, 3)), $urandom, CHANNELS'($urandom),
                  ($urandom_range(0, 7) == 0) ? CHANNELS'($urandom) : '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
